// File: rtl/dso_uart_pkg.sv
// Shared constants and state types for the scope's host UART link.
package dso_uart_pkg;

    localparam logic [7:0] POS_ACK  = 8'hA5;
    localparam logic [7:0] NEG_ACK  = 8'hEE;

    localparam logic [7:0] DUMP_CH  = 8'h01;
    localparam logic [7:0] CFG_GAIN = 8'h02;
    localparam logic [7:0] TRIG_LVL = 8'h03;
    localparam logic [7:0] TRIG_POS = 8'h04;
    localparam logic [7:0] SET_DEC  = 8'h05;
    localparam logic [7:0] TRIG_CFG = 8'h06;
    localparam logic [7:0] TRIG_RD  = 8'h07;
    localparam logic [7:0] EEP_WRT  = 8'h08;
    localparam logic [7:0] EEP_RD   = 8'h09;

    typedef enum logic [1:0] {
        WAIT_B2,
        WAIT_B1,
        WAIT_B0,
        READY
    } asm_state_e;

    typedef enum logic [1:0] {
        RX_IDLE,
        RX_START,
        RX_DATA,
        RX_STOP
    } rx_state_e;

endpackage

// File: rtl/uart_cmd_resp_if.sv
// Dispatcher-side command/response bus of the host UART responder.
interface uart_cmd_resp_if;
    logic [23:0] cmd;
    logic        cmd_rdy;
    logic        clr_cmd_rdy;
    logic [7:0]  resp;
    logic        send_resp;
    logic        resp_sent;
    logic        tx_busy;
    logic        frame_err;
    logic        overrun;

    modport slave (
        output cmd, cmd_rdy, resp_sent, tx_busy, frame_err, overrun,
        input  clr_cmd_rdy, resp, send_resp
    );

    modport master (
        input  cmd, cmd_rdy, resp_sent, tx_busy, frame_err, overrun,
        output clr_cmd_rdy, resp, send_resp
    );
endinterface

// File: rtl/uart_tx_byte.sv
// 8N1 byte serialiser, LSB first; tx_done pulses on the cycle tx_busy falls.
module uart_tx_byte #(
    parameter int unsigned BAUD_DIV = 2604
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       trmt,
    input  logic [7:0] tx_data,
    output logic       TX,
    output logic       tx_busy,
    output logic       tx_done
);
    localparam int unsigned BW = $clog2(BAUD_DIV) + 1;

    logic          busy_q, busy_d;
    logic          tx_q, tx_d;
    logic          done_q, done_d;
    logic [BW-1:0] cnt_q, cnt_d;
    logic [3:0]    bit_q, bit_d;
    logic [7:0]    shift_q, shift_d;

    // bit_q: 0 = start, 1..8 = data, 9 = stop; shifter back-fills ones so it yields the stop level
    always_comb begin
        busy_d  = busy_q;
        tx_d    = tx_q;
        done_d  = 1'b0;
        cnt_d   = cnt_q;
        bit_d   = bit_q;
        shift_d = shift_q;
        if (!busy_q) begin
            if (trmt) begin
                busy_d  = 1'b1;
                tx_d    = 1'b0;
                shift_d = tx_data;
                cnt_d   = '0;
                bit_d   = '0;
            end
        end else if (cnt_q == BW'(BAUD_DIV - 1)) begin
            cnt_d = '0;
            if (bit_q == 4'd9) begin
                busy_d = 1'b0;
                tx_d   = 1'b1;
                done_d = 1'b1;
            end else begin
                bit_d   = bit_q + 4'd1;
                tx_d    = shift_q[0];
                shift_d = {1'b1, shift_q[7:1]};
            end
        end else begin
            cnt_d = cnt_q + BW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            busy_q  <= 1'b0;
            tx_q    <= 1'b1;
            done_q  <= 1'b0;
            cnt_q   <= '0;
            bit_q   <= '0;
            shift_q <= '0;
        end else begin
            busy_q  <= busy_d;
            tx_q    <= tx_d;
            done_q  <= done_d;
            cnt_q   <= cnt_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
        end
    end

    assign TX      = tx_q;
    assign tx_busy = busy_q;
    assign tx_done = done_q;
endmodule

// File: rtl/uart_cmd_resp.sv
// Host UART responder: assembles 3-byte commands from RX and serialises 1-byte responses on TX.
module uart_cmd_resp
    import dso_uart_pkg::*;
#(
    parameter int unsigned BAUD_DIV = 2604,
    parameter int unsigned GAP_TO   = 65535
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             RX,
    output logic             TX,
    uart_cmd_resp_if.slave   bus
);
    localparam int unsigned BW   = $clog2(BAUD_DIV) + 1;
    localparam int unsigned GW   = $clog2(GAP_TO + 1);
    localparam int unsigned HALF = BAUD_DIV / 2;

    logic          rx_s1_q, rx_s2_q, rx_s3_q;
    rx_state_e     rx_state_q, rx_state_d;
    logic [BW-1:0] rx_cnt_q, rx_cnt_d;
    logic [2:0]    rx_bit_q, rx_bit_d;
    logic [7:0]    rx_shift_q, rx_shift_d;
    logic          byte_vld, rx_ferr;

    asm_state_e    state_q, state_d;
    logic [23:0]   cmd_q, cmd_d;
    logic          cmd_rdy_q, cmd_rdy_d;
    logic          overrun_q, overrun_d;
    logic          frame_err_q, frame_err_d;
    logic [GW-1:0] gap_q, gap_d;

    logic          tx_busy, tx_done;

    // Receiver: falling edge of synchronised RX arms a half-bit start qualification
    always_comb begin
        rx_state_d = rx_state_q;
        rx_cnt_d   = rx_cnt_q;
        rx_bit_d   = rx_bit_q;
        rx_shift_d = rx_shift_q;
        byte_vld   = 1'b0;
        rx_ferr    = 1'b0;
        case (rx_state_q)
            RX_IDLE: begin
                if (rx_s3_q && !rx_s2_q) begin
                    rx_state_d = RX_START;
                    rx_cnt_d   = '0;
                end
            end
            RX_START: begin
                if (rx_cnt_q == BW'(HALF - 1)) begin
                    rx_cnt_d   = '0;
                    rx_bit_d   = '0;
                    rx_state_d = rx_s2_q ? RX_IDLE : RX_DATA;
                end else begin
                    rx_cnt_d = rx_cnt_q + BW'(1);
                end
            end
            RX_DATA: begin
                if (rx_cnt_q == BW'(BAUD_DIV - 1)) begin
                    rx_cnt_d   = '0;
                    rx_shift_d = {rx_s2_q, rx_shift_q[7:1]};
                    rx_bit_d   = rx_bit_q + 3'd1;
                    if (rx_bit_q == 3'd7) rx_state_d = RX_STOP;
                end else begin
                    rx_cnt_d = rx_cnt_q + BW'(1);
                end
            end
            RX_STOP: begin
                if (rx_cnt_q == BW'(BAUD_DIV - 1)) begin
                    rx_cnt_d   = '0;
                    rx_state_d = RX_IDLE;
                    byte_vld   = rx_s2_q;
                    rx_ferr    = !rx_s2_q;
                end else begin
                    rx_cnt_d = rx_cnt_q + BW'(1);
                end
            end
            default: rx_state_d = RX_IDLE;
        endcase
    end

    // Assembler: a clear in READY takes effect before a coincident byte is considered
    always_comb begin
        state_d   = state_q;
        cmd_d     = cmd_q;
        gap_d     = '0;
        overrun_d = 1'b0;
        case (state_q)
            WAIT_B2: begin
                if (byte_vld) begin
                    cmd_d[23:16] = rx_shift_q;
                    state_d      = WAIT_B1;
                end
            end
            WAIT_B1, WAIT_B0: begin
                if (byte_vld) begin
                    if (state_q == WAIT_B1) begin
                        cmd_d[15:8] = rx_shift_q;
                        state_d     = WAIT_B0;
                    end else begin
                        cmd_d[7:0] = rx_shift_q;
                        state_d    = READY;
                    end
                end else if (rx_ferr || gap_q == GW'(GAP_TO)) begin
                    state_d = WAIT_B2;
                end else if (rx_state_q == RX_IDLE) begin
                    gap_d = gap_q + GW'(1);
                end
            end
            READY: begin
                if (bus.clr_cmd_rdy) begin
                    if (byte_vld) begin
                        cmd_d[23:16] = rx_shift_q;
                        state_d      = WAIT_B1;
                    end else begin
                        state_d = WAIT_B2;
                    end
                end else if (byte_vld) begin
                    overrun_d = 1'b1;
                end
            end
            default: state_d = WAIT_B2;
        endcase
        cmd_rdy_d   = (state_d == READY);
        frame_err_d = rx_ferr;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rx_s1_q     <= 1'b1;
            rx_s2_q     <= 1'b1;
            rx_s3_q     <= 1'b1;
            rx_state_q  <= RX_IDLE;
            rx_cnt_q    <= '0;
            rx_bit_q    <= '0;
            rx_shift_q  <= '0;
            state_q     <= WAIT_B2;
            cmd_q       <= '0;
            cmd_rdy_q   <= 1'b0;
            overrun_q   <= 1'b0;
            frame_err_q <= 1'b0;
            gap_q       <= '0;
        end else begin
            rx_s1_q     <= RX;
            rx_s2_q     <= rx_s1_q;
            rx_s3_q     <= rx_s2_q;
            rx_state_q  <= rx_state_d;
            rx_cnt_q    <= rx_cnt_d;
            rx_bit_q    <= rx_bit_d;
            rx_shift_q  <= rx_shift_d;
            state_q     <= state_d;
            cmd_q       <= cmd_d;
            cmd_rdy_q   <= cmd_rdy_d;
            overrun_q   <= overrun_d;
            frame_err_q <= frame_err_d;
            gap_q       <= gap_d;
        end
    end

    uart_tx_byte #(.BAUD_DIV(BAUD_DIV)) u_tx (
        .clk     (clk),
        .rst     (rst),
        .trmt    (bus.send_resp),
        .tx_data (bus.resp),
        .TX      (TX),
        .tx_busy (tx_busy),
        .tx_done (tx_done)
    );

    assign bus.cmd       = cmd_q;
    assign bus.cmd_rdy   = cmd_rdy_q;
    assign bus.overrun   = overrun_q;
    assign bus.frame_err = frame_err_q;
    assign bus.tx_busy   = tx_busy;
    assign bus.resp_sent = tx_done;
endmodule

// File: tb/tb_uart_cmd_resp.sv
// Scoreboard bench for uart_cmd_resp: host byte driver, TX frame decoder and command monitor.
module tb_uart_cmd_resp;
    localparam int unsigned BD = 16;
    localparam int unsigned GT = 400;

    logic clk = 1'b0;
    logic rst;
    logic RX;
    logic TX;

    uart_cmd_resp_if bus();

    uart_cmd_resp #(.BAUD_DIV(BD), .GAP_TO(GT)) dut (
        .clk (clk),
        .rst (rst),
        .RX  (RX),
        .TX  (TX),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;
    int ovr_cnt = 0;
    int ferr_cnt = 0;
    int frames = 0;
    logic [23:0] exp_cmd_q[$];
    logic [7:0]  exp_resp_q[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Command monitor: every rising cmd_rdy consumes one expected command
    logic rdy_prev = 1'b0;
    always @(negedge clk) begin
        if (rst) begin
            rdy_prev = 1'b0;
        end else begin
            if (bus.cmd_rdy && !rdy_prev) begin
                if (exp_cmd_q.size() == 0)
                    check("cmd_unexpected", 32'(bus.cmd), 32'hFFFF_FFFF);
                else
                    check("cmd", 32'(bus.cmd), 32'(exp_cmd_q.pop_front()));
            end
            rdy_prev = bus.cmd_rdy;
            if (bus.overrun)   ovr_cnt++;
            if (bus.frame_err) ferr_cnt++;
        end
    end

    // TX decoder: records each bit level at its first busy cycle and checks it holds for the whole bit
    int         bi = 0;
    int         tx_glitch = 0;
    logic [9:0] bits = '0;
    logic [3:0] bidx;
    always @(negedge clk) begin
        if (rst) begin
            bi = 0;
            tx_glitch = 0;
        end else begin
            if (bus.tx_busy) begin
                if (bi < 160) begin
                    bidx = 4'(bi / 16);
                    if (bi % 16 == 0) bits[bidx] = TX;
                    else if (TX !== bits[bidx]) tx_glitch++;
                end
                bi++;
            end
            if (bus.resp_sent) begin
                frames++;
                check("tx_frame_len", 32'(bi), 32'd160);
                check("tx_busy_at_sent", 32'(bus.tx_busy), 32'd0);
                check("tx_start_stop", 32'({bits[9], bits[0]}), 32'h2);
                check("tx_bit_stable", 32'(tx_glitch), 32'd0);
                if (exp_resp_q.size() == 0)
                    check("resp_unexpected", 32'(bits[8:1]), 32'h100);
                else
                    check("resp_rcv", 32'(bits[8:1]), 32'(exp_resp_q.pop_front()));
                bi = 0;
                tx_glitch = 0;
            end
        end
    end

    task automatic send_byte(input logic [7:0] b, input logic stop);
        @(negedge clk); RX = 1'b0;
        repeat (BD) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            RX = b[i];
            repeat (BD) @(negedge clk);
        end
        RX = stop;
        repeat (BD) @(negedge clk);
        RX = 1'b1;
    endtask

    task automatic send_cmd(input logic [23:0] c);
        send_byte(c[23:16], 1'b1);
        send_byte(c[15:8], 1'b1);
        send_byte(c[7:0], 1'b1);
    endtask

    task automatic wait_rdy(input int lim);
        int n = 0;
        while (!bus.cmd_rdy && n < lim) begin
            @(negedge clk);
            n++;
        end
        check("cmd_rdy_in_time", 32'(bus.cmd_rdy), 32'd1);
    endtask

    task automatic clear_cmd(input logic [23:0] held);
        @(negedge clk); bus.clr_cmd_rdy = 1'b1;
        @(negedge clk); bus.clr_cmd_rdy = 1'b0;
        check("cmd_rdy_cleared", 32'(bus.cmd_rdy), 32'd0);
        check("cmd_held", 32'(bus.cmd), 32'(held));
    endtask

    task automatic send_resp(input logic [7:0] r, input logic expect_frame);
        if (expect_frame) exp_resp_q.push_back(r);
        @(negedge clk); bus.resp = r; bus.send_resp = 1'b1;
        @(negedge clk); bus.send_resp = 1'b0;
        check("tx_busy_after_send", 32'(bus.tx_busy), 32'd1);
        check("tx_low_in_frame", 32'(expect_frame ? TX : 1'b0), 32'd0);
    endtask

    task automatic wait_frames(input int target, input int lim);
        int n = 0;
        while (frames < target && n < lim) begin
            @(negedge clk);
            n++;
        end
        check("resp_sent_seen", 32'(frames >= target), 32'd1);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

    initial begin
        int o0, f0, fr0;
        rst = 1'b1;
        RX  = 1'b1;
        bus.clr_cmd_rdy = 1'b0;
        bus.resp        = 8'h00;
        bus.send_resp   = 1'b0;
        repeat (3) @(negedge clk);
        check("reset_outs", 32'({TX, bus.cmd_rdy, bus.tx_busy, bus.resp_sent, bus.frame_err, bus.overrun}), 32'h20);
        check("reset_cmd", 32'(bus.cmd), 32'd0);
        rst = 1'b0;
        repeat (5) @(negedge clk);

        // 1: basic command and clear
        exp_cmd_q.push_back(24'h020003);
        send_cmd(24'h020003);
        wait_rdy(BD);
        clear_cmd(24'h020003);

        // 2: ACK response
        fr0 = frames;
        send_resp(8'hA5, 1'b1);
        wait_frames(fr0 + 1, 400);

        // 3: overrun while a command is pending
        exp_cmd_q.push_back(24'h010203);
        send_cmd(24'h010203);
        wait_rdy(BD);
        o0 = ovr_cnt;
        send_cmd(24'h112233);
        check("overrun_count", 32'(ovr_cnt - o0), 32'd3);
        check("cmd_after_overrun", 32'(bus.cmd), 32'h010203);
        check("rdy_after_overrun", 32'(bus.cmd_rdy), 32'd1);
        clear_cmd(24'h010203);
        exp_cmd_q.push_back(24'h0480FF);
        send_cmd(24'h0480FF);
        wait_rdy(BD);
        clear_cmd(24'h0480FF);

        // 4: inter-byte gap timeout discards the stale byte
        send_byte(8'h03, 1'b1);
        repeat (500) @(negedge clk);
        exp_cmd_q.push_back(24'h05002E);
        send_cmd(24'h05002E);
        wait_rdy(BD);
        clear_cmd(24'h05002E);

        // 5: framing error, then glitch, then a clean command
        f0 = ferr_cnt;
        send_byte(8'h07, 1'b1);
        send_byte(8'h55, 1'b0);
        repeat (32) @(negedge clk);
        check("frame_err_count", 32'(ferr_cnt - f0), 32'd1);
        @(negedge clk); RX = 1'b0;
        repeat (4) @(negedge clk);
        RX = 1'b1;
        repeat (100) @(negedge clk);
        check("glitch_no_ferr", 32'(ferr_cnt - f0), 32'd1);
        check("glitch_no_cmd", 32'(bus.cmd_rdy), 32'd0);
        exp_cmd_q.push_back(24'h090011);
        send_cmd(24'h090011);
        wait_rdy(BD);
        clear_cmd(24'h090011);

        // 6: reset mid-RX and mid-TX, then a busy strobe is ignored
        exp_cmd_q.push_back(24'h081234);
        send_cmd(24'h081234);
        wait_rdy(BD);
        send_resp(8'h5A, 1'b0);
        fork
            send_byte(8'hFF, 1'b1);
            begin
                repeat (60) @(negedge clk);
                rst = 1'b1;
                @(negedge clk);
                check("rst_mid_outs", 32'({TX, bus.tx_busy, bus.cmd_rdy}), 32'h4);
                check("rst_mid_cmd", 32'(bus.cmd), 32'd0);
                rst = 1'b0;
            end
        join
        repeat (20) @(negedge clk);
        fr0 = frames;
        send_resp(8'h3C, 1'b1);
        repeat (40) @(negedge clk);
        send_resp(8'hC3, 1'b0);
        wait_frames(fr0 + 1, 400);
        repeat (200) @(negedge clk);
        check("single_frame", 32'(frames - fr0), 32'd1);

        check("cmd_queue_drained", 32'(exp_cmd_q.size()), 32'd0);
        check("resp_queue_drained", 32'(exp_resp_q.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
